// File: rtl/imem_loader.sv
// Byte-stream loader: packs big-endian bytes into 32-bit words and writes them to instruction memory from address 0.
// Latency: one cycle from the 4th byte of a word to the registered write strobe.
// No backpressure: a byte may arrive every cycle and is accepted only while loading.
module imem_loader #(
    parameter int          IMEM_DEPTH = 256,
    parameter int          ADDR_W     = 10,
    parameter logic [31:0] HALT_WORD  = 32'hFFFF_FFFF
) (
    input  logic                          i_clk,
    input  logic                          i_reset,
    input  logic                          i_load_start,
    input  logic                          i_byte_valid,
    input  logic [7:0]                    i_byte,
    output logic                          o_wr_en,
    output logic [ADDR_W-1:0]             o_wr_addr,
    output logic [31:0]                   o_wr_data,
    output logic                          o_cpu_hold,
    output logic                          o_done,
    output logic                          o_full,
    output logic [$clog2(IMEM_DEPTH):0]   o_word_count
);

    localparam int IDX_W = $clog2(IMEM_DEPTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [1:0]         byte_cnt;
    logic [23:0]        acc;
    logic [IDX_W-1:0]   word_idx;

    logic               byte_take;
    logic               word_last;
    logic [31:0]        word_new;
    logic               is_halt;
    logic               mem_end;
    logic               sess_start;

    assign byte_take  = (state == LOAD) && i_byte_valid;
    assign word_last  = byte_take && (byte_cnt == 2'd3);
    assign word_new   = {acc, i_byte};
    assign is_halt    = (word_new == HALT_WORD);
    assign mem_end    = (word_idx == IDX_W'(IMEM_DEPTH - 1));
    assign sess_start = (state == IDLE) && i_load_start;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (i_load_start) state_nxt = LOAD;
            LOAD:    if (word_last && (is_halt || mem_end)) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // DONE keeps the pipeline held for its single cycle so the last write lands first.
    always_comb begin
        o_cpu_hold = 1'b0;
        o_done     = 1'b0;
        case (state)
            LOAD:    o_cpu_hold = 1'b1;
            DONE: begin
                o_cpu_hold = 1'b1;
                o_done     = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            byte_cnt     <= '0;
            acc          <= '0;
            word_idx     <= '0;
            o_wr_en      <= 1'b0;
            o_wr_addr    <= '0;
            o_wr_data    <= '0;
            o_full       <= 1'b0;
            o_word_count <= '0;
        end else begin
            o_wr_en <= word_last;
            if (sess_start) begin
                byte_cnt     <= '0;
                acc          <= '0;
                word_idx     <= '0;
                o_full       <= 1'b0;
                o_word_count <= '0;
            end
            if (byte_take) begin
                acc      <= {acc[15:0], i_byte};
                byte_cnt <= byte_cnt + 2'd1;
            end
            if (word_last) begin
                o_wr_data    <= word_new;
                o_wr_addr    <= ADDR_W'({word_idx, 2'b00});
                word_idx     <= word_idx + 1'b1;
                o_word_count <= o_word_count + 1'b1;
                // A HALT in the last slot is a normal termination, not an overflow.
                if (!is_halt && mem_end) o_full <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: reset, single word, HALT session, full memory, mid-session reset, gapped bytes.
module tb_imem_loader;

    logic        i_clk = 1'b0;
    logic        i_reset;
    logic        i_load_start;
    logic        i_byte_valid;
    logic [7:0]  i_byte;
    logic        o_wr_en;
    logic [9:0]  o_wr_addr;
    logic [31:0] o_wr_data;
    logic        o_cpu_hold;
    logic        o_done;
    logic        o_full;
    logic [8:0]  o_word_count;

    int n_cmp = 0;
    int n_err = 0;

    imem_loader #(
        .IMEM_DEPTH (256),
        .ADDR_W     (10),
        .HALT_WORD  (32'hFFFF_FFFF)
    ) dut (
        .i_clk        (i_clk),
        .i_reset      (i_reset),
        .i_load_start (i_load_start),
        .i_byte_valid (i_byte_valid),
        .i_byte       (i_byte),
        .o_wr_en      (o_wr_en),
        .o_wr_addr    (o_wr_addr),
        .o_wr_data    (o_wr_data),
        .o_cpu_hold   (o_cpu_hold),
        .o_done       (o_done),
        .o_full       (o_full),
        .o_word_count (o_word_count)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Drive one cycle of inputs, then let outputs settle 1 ns past the edge.
    task automatic cyc(input logic v, input logic [7:0] b, input logic s);
        i_byte_valid = v;
        i_byte       = b;
        i_load_start = s;
        @(posedge i_clk);
        #1;
    endtask

    task automatic do_reset();
        i_byte_valid = 1'b0;
        i_load_start = 1'b0;
        i_byte       = 8'h00;
        i_reset      = 1'b1;
        @(posedge i_clk);
        #1;
        i_reset      = 1'b0;
    endtask

    // Sends one word MSB first; idle cycles before each byte may pulse i_load_start.
    task automatic send_word(input logic [31:0] w, input int gap_seed, input logic pulse,
                             input logic [31:0] exp_addr, input int exp_cnt);
        logic [7:0] bb;
        for (int b = 0; b < 4; b++) begin
            for (int g = 0; g < (gap_seed + b) % 4; g++) cyc(1'b0, 8'h00, pulse);
            bb = 8'(w >> (24 - 8 * b));
            cyc(1'b1, bb, 1'b0);
        end
        check("wr_en",  32'(o_wr_en), 32'd1);
        check("wr_addr", 32'(o_wr_addr), exp_addr);
        check("wr_data", o_wr_data, w);
        check("word_count", 32'(o_word_count), 32'(exp_cnt));
    endtask

    logic seen_wr;

    initial begin
        i_reset      = 1'b1;
        i_load_start = 1'b0;
        i_byte_valid = 1'b0;
        i_byte       = 8'h00;
        #2;
        check("rst_wr_en", 32'(o_wr_en), 32'd0);
        check("rst_addr",  32'(o_wr_addr), 32'd0);
        check("rst_data",  o_wr_data, 32'd0);
        check("rst_hold",  32'(o_cpu_hold), 32'd0);
        check("rst_done",  32'(o_done), 32'd0);
        check("rst_full",  32'(o_full), 32'd0);
        check("rst_count", 32'(o_word_count), 32'd0);
        @(posedge i_clk);
        #1;
        i_reset = 1'b0;

        // Idle with random byte traffic: nothing may be written.
        seen_wr = 1'b0;
        for (int k = 0; k < 10; k++) begin
            cyc(1'($urandom_range(1)), 8'($urandom), 1'b0);
            seen_wr |= o_wr_en;
        end
        check("idle_no_write", 32'(seen_wr), 32'd0);
        check("idle_hold", 32'(o_cpu_hold), 32'd0);

        // Single word.
        cyc(1'b0, 8'h00, 1'b1);
        check("load_hold", 32'(o_cpu_hold), 32'd1);
        send_word(32'h2008_0005, 0, 1'b0, 32'h0, 1);
        check("w1_hold", 32'(o_cpu_hold), 32'd1);
        cyc(1'b0, 8'h00, 1'b0);
        check("w1_strobe_drop", 32'(o_wr_en), 32'd0);
        check("w1_data_hold", o_wr_data, 32'h2008_0005);

        // Three words then HALT, back to back.
        do_reset();
        cyc(1'b0, 8'h00, 1'b1);
        send_word(32'h3C01_1001, 0, 1'b0, 32'd0, 1);
        send_word(32'h3421_0004, 0, 1'b0, 32'd4, 2);
        send_word(32'h8C22_0000, 0, 1'b0, 32'd8, 3);
        send_word(32'hFFFF_FFFF, 0, 1'b0, 32'd12, 4);
        check("halt_done", 32'(o_done), 32'd1);
        check("halt_hold", 32'(o_cpu_hold), 32'd1);
        cyc(1'b1, 8'h55, 1'b0);
        check("halt_done_pulse", 32'(o_done), 32'd0);
        check("halt_release", 32'(o_cpu_hold), 32'd0);
        check("halt_no_write", 32'(o_wr_en), 32'd0);
        check("halt_count", 32'(o_word_count), 32'd4);
        check("halt_full", 32'(o_full), 32'd0);

        // Fill memory without HALT.
        do_reset();
        cyc(1'b0, 8'h00, 1'b1);
        for (int i = 0; i < 256; i++) begin
            send_word(32'h1000_0000 + 32'(i), 0, 1'b0, 32'(i * 4), i + 1);
            if (i == 254) check("full_early", 32'(o_full), 32'd0);
        end
        check("full_flag", 32'(o_full), 32'd1);
        check("full_done", 32'(o_done), 32'd1);
        check("full_last_addr", 32'(o_wr_addr), 32'h3FC);
        cyc(1'b0, 8'h00, 1'b0);
        check("full_release", 32'(o_cpu_hold), 32'd0);
        seen_wr = 1'b0;
        for (int b = 0; b < 4; b++) begin
            cyc(1'b1, 8'h12, 1'b0);
            seen_wr |= o_wr_en;
        end
        check("full_257_ignored", 32'(seen_wr), 32'd0);
        check("full_count_hold", 32'(o_word_count), 32'd256);
        check("full_flag_hold", 32'(o_full), 32'd1);

        // Reset mid-word discards stale bytes; start with a byte drops the byte.
        do_reset();
        cyc(1'b0, 8'h00, 1'b1);
        cyc(1'b1, 8'h01, 1'b0);
        cyc(1'b1, 8'h02, 1'b0);
        do_reset();
        check("midrst_hold", 32'(o_cpu_hold), 32'd0);
        check("midrst_wr_en", 32'(o_wr_en), 32'd0);
        cyc(1'b1, 8'h11, 1'b1);
        send_word(32'hAABB_CCDD, 0, 1'b0, 32'd0, 1);

        // Gapped bytes with start pulses during LOAD.
        do_reset();
        cyc(1'b0, 8'h00, 1'b1);
        send_word(32'h0123_4567, 1, 1'b1, 32'd0, 1);
        send_word(32'h89AB_CDEF, 2, 1'b1, 32'd4, 2);
        send_word(32'h0C0F_FEE0, 3, 1'b1, 32'd8, 3);
        check("gap_hold", 32'(o_cpu_hold), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Writer side of the instruction memory that the IF stage reads.
- Takes a byte stream (e.g. from a UART receiver) and assembles big-endian 32-bit MIPS words.
- Writes each word to consecutive instruction-memory locations starting at address 0.
- Holds the CPU pipeline while loading and releases it once a HALT word arrives or memory is full.

Parameters:
- IMEM_DEPTH, 256, number of 32-bit words in instruction memory (power of 2).
- ADDR_W, 10, byte-address width of o_wr_addr; equals log2(IMEM_DEPTH)+2.
- HALT_WORD, 32'hFFFFFFFF, terminating instruction. It is itself written, then loading ends.

Ports:
- i_clk  input  1  system clock, rising edge.
- i_reset  input  1  asynchronous, active-high reset.
- i_load_start  input  1  one-cycle request to begin a load session.
- i_byte_valid  input  1  i_byte is valid this cycle; accepted only in LOAD.
- i_byte  input  8  data byte; first byte of each word is the MSB.
- o_wr_en  output  1  instruction-memory write strobe, one cycle per word.
- o_wr_addr  output  ADDR_W  byte address of the write; always a multiple of 4.
- o_wr_data  output  32  assembled instruction word.
- o_cpu_hold  output  1  keeps the pipeline stalled/reset while high.
- o_done  output  1  one-cycle pulse at the end of a load session.
- o_full  output  1  sticky flag: the session ended because memory filled without a HALT.
- o_word_count  output  log2(IMEM_DEPTH)+1  words written in the current/last session.

Behaviour:
- Reset (async, any state): state=IDLE; every output 0; byte counter, accumulator and word index cleared. A partial word is discarded.
- States:
  - IDLE: o_cpu_hold=0; i_byte_valid ignored. i_load_start -> LOAD.
  - Entering LOAD at that edge: clear byte counter, word index, o_word_count and o_full.
  - LOAD: o_cpu_hold=1; i_load_start ignored.
  - DONE: lasts exactly one cycle with o_done=1 and o_cpu_hold=1, then -> IDLE with o_cpu_hold=0.
- Word assembly in LOAD: each i_byte_valid edge does acc <= {acc[23:0], i_byte} and byte_cnt <= byte_cnt+1 (2-bit, wraps 3->0).
- Write issue, on the edge that samples the 4th byte (byte_cnt==3):
  - o_wr_en=1, o_wr_data={acc[23:0], i_byte}, o_wr_addr=word_idx<<2, all registered. Latency is one cycle from the 4th byte to a visible strobe.
  - word_idx and o_word_count increment.
  - o_wr_en stays high for exactly one cycle, then drops unless the next write is issued.
- Termination, evaluated at the same edge as the write:
  - Written word equals HALT_WORD -> DONE.
  - Otherwise, word_idx equals IMEM_DEPTH-1 -> DONE with o_full=1.
  - If both hold, HALT wins and o_full=0.
- Back-to-back bytes every cycle are supported with no backpressure. A 5th byte arriving while o_wr_en is high is accumulated normally.
- In DONE and IDLE, i_byte_valid is ignored; no write occurs.
- o_wr_addr/o_wr_data hold their last values when o_wr_en=0.
- o_word_count and o_full hold after DONE until the next i_load_start.
- i_load_start together with i_byte_valid in IDLE: start is taken, the byte is dropped.
- Reset mid-word or mid-session: no further writes; the CPU is released because o_cpu_hold=0.

Test Plan:
- Reset then idle 10 cycles -> all outputs 0; random i_byte_valid traffic produces no o_wr_en.
- Start, then bytes 20,08,00,05 (one per cycle) -> one cycle after the 4th byte: o_wr_en=1, addr=0, data=0x20080005, o_word_count=1, o_cpu_hold=1.
- Start, 3 words back-to-back then FF,FF,FF,FF -> writes at addr 0,4,8,12 (last data 0xFFFFFFFF); then one cycle o_done=1; then o_cpu_hold=0; o_word_count=4; o_full=0.
- Start, 256 non-HALT words -> last write at addr 0x3FC, o_full=1, o_done pulse, o_word_count=256; a 257th word is ignored (no o_wr_en).
- Start, 2 bytes, assert i_reset, release, start, 4 bytes AA,BB,CC,DD -> single write at addr 0, data 0xAABBCCDD (stale bytes discarded).
- Bytes with gaps of 0-3 idle cycles, plus i_load_start pulsed during LOAD -> data assembled correctly, no restart, addresses unchanged.
